// File: rtl/vis_input_conditioner.sv
// ---------------------------------------------------------------------------
// vis_input_conditioner
//   Front end of the 32-bit seven-segment visualizer. Debounces the board
//   push-button into a half-select level, holds the CPU result word in a
//   stable display register (with optional freeze) and emits a periodic
//   scan tick for display pacing.
//
// Optional feature macro: AUTO_TOGGLE_EN
//   When defined, toggle_btn also inverts every AUTO_PERIOD cycles while the
//   button FSM is RELEASED. An accepted press restarts that period.
//
// Ports:
//   CLK         in   system clock, all logic on posedge
//   RST_N       in   synchronous active-low reset
//   btn_raw     in   asynchronous bouncy push-button, active-high
//   freeze      in   asynchronous level switch, 1 = hold displayed word
//   data_in     in   [31:0] CPU result word
//   data_valid  in   1-cycle qualifier for data_in
//   data_bits   out  [31:0] held word to visualizer
//   toggle_btn  out  half-select level (1 = low half, 0 = high half)
//   press_pulse out  1-cycle pulse per accepted press
//   scan_tick   out  1-cycle pulse every TICK_DIV cycles
//   frozen      out  synchronized freeze status
// ---------------------------------------------------------------------------
module vis_input_conditioner #(
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [15:0] TICK_DIV    = 16'd1000,
    parameter logic [31:0] AUTO_PERIOD = 32'd50000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        btn_raw,
    input  logic        freeze,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic [31:0] data_bits,
    output logic        toggle_btn,
    output logic        press_pulse,
    output logic        scan_tick,
    output logic        frozen
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    logic        btn_meta_q, btn_sync_q;
    logic        frz_meta_q, frz_sync_q;
    deb_state_t  state_q, state_d;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        toggle_q, toggle_d;
    logic        press_q, press_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        scan_tick_q, scan_tick_d;
    logic [31:0] data_q, data_d;
    logic        press_accept;

    // Debounce FSM next-state
    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        press_accept = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_sync_q) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = 16'd1;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
                    state_d      = PRESSED;
                    deb_cnt_d    = '0;
                    press_accept = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!btn_sync_q) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = 16'd1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync_q) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = RELEASED;
                deb_cnt_d = '0;
            end
        endcase
        press_d = press_accept;
    end

`ifdef AUTO_TOGGLE_EN
    logic [31:0] auto_cnt_q, auto_cnt_d;

    // A press takes priority over a coincident auto swap: one inversion only.
    always_comb begin
        toggle_d   = toggle_q;
        auto_cnt_d = auto_cnt_q;
        if (press_accept) begin
            toggle_d   = ~toggle_q;
            auto_cnt_d = '0;
        end else if (state_q == RELEASED) begin
            if (auto_cnt_q == AUTO_PERIOD - 32'd1) begin
                toggle_d   = ~toggle_q;
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) auto_cnt_q <= '0;
        else        auto_cnt_q <= auto_cnt_d;
    end
`else
    always_comb begin
        toggle_d = press_accept ? ~toggle_q : toggle_q;
    end
`endif

    // Scan tick is registered together with the counter, so it is high in
    // exactly the cycle the counter holds TICK_DIV-1.
    always_comb begin
        tick_cnt_d  = (tick_cnt_q == TICK_DIV - 16'd1) ? '0 : tick_cnt_q + 16'd1;
        scan_tick_d = (tick_cnt_d == TICK_DIV - 16'd1);
    end

    always_comb begin
        data_d = (data_valid && !frz_sync_q) ? data_in : data_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            frz_meta_q  <= 1'b0;
            frz_sync_q  <= 1'b0;
            state_q     <= RELEASED;
            deb_cnt_q   <= '0;
            toggle_q    <= 1'b1;
            press_q     <= 1'b0;
            tick_cnt_q  <= '0;
            scan_tick_q <= 1'b0;
            data_q      <= '0;
        end else begin
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
            frz_meta_q  <= freeze;
            frz_sync_q  <= frz_meta_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            toggle_q    <= toggle_d;
            press_q     <= press_d;
            tick_cnt_q  <= tick_cnt_d;
            scan_tick_q <= scan_tick_d;
            data_q      <= data_d;
        end
    end

    assign data_bits   = data_q;
    assign toggle_btn  = toggle_q;
    assign press_pulse = press_q;
    assign scan_tick   = scan_tick_q;
    assign frozen      = frz_sync_q;

endmodule

// File: tb/tb_vis_input_conditioner.sv
module tb_vis_input_conditioner;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        btn_raw;
    logic        freeze;
    logic [31:0] data_in;
    logic        data_valid;
    logic [31:0] data_bits;
    logic        toggle_btn;
    logic        press_pulse;
    logic        scan_tick;
    logic        frozen;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] data_exp_q[$];
    int          press_exp_q[$];
    int          tick_exp_q[$];
    logic        exp_toggle;
    logic [31:0] exp_word;

    vis_input_conditioner #(
        .DEB_CYCLES (16'd4),
        .TICK_DIV   (16'd5),
        .AUTO_PERIOD(32'd8)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .btn_raw    (btn_raw),
        .freeze     (freeze),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_bits  (data_bits),
        .toggle_btn (toggle_btn),
        .press_pulse(press_pulse),
        .scan_tick  (scan_tick),
        .frozen     (frozen)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        int exp_e;
        RST_N = 1'b0; btn_raw = 1'b1; data_valid = 1'b1;
        data_in = 32'hA5A5A5A5; freeze = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            obs = {data_bits, toggle_btn, press_pulse, scan_tick, frozen};
            vectors++;
            if (obs !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: got %h want %h", c, obs, {32'h0, 4'b1000});
            end
        end
        RST_N = 1'b1; data_valid = 1'b0;
        exp_toggle = 1'b1;
        press_exp_q.push_back(6);
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (press_pulse) begin
                vectors++;
                if (press_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL reset_first_press unexpected pulse at edge %0d", e);
                end else begin
                    exp_e = press_exp_q.pop_front();
                    if (e != exp_e) begin
                        miscompares++;
                        $display("FAIL reset_first_press pulse edge got %0d want %0d", e, exp_e);
                    end
                end
            end
            if (e == 6) exp_toggle = 1'b0;
            vectors++;
            if (toggle_btn !== exp_toggle) begin
                miscompares++;
                $display("FAIL reset_first_toggle edge %0d got %b want %b", e, toggle_btn, exp_toggle);
            end
        end
        vectors++;
        if (press_exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_first_press missing pulses got %0d pending want 0", press_exp_q.size());
            press_exp_q.delete();
        end
        btn_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_clean_press();
        int pulses;
        int exp_e;
        for (int p = 0; p < 2; p++) begin
            pulses = 0;
            btn_raw = 1'b1;
            press_exp_q.push_back(6);
            for (int e = 1; e <= 20; e++) begin
                tick();
                if (press_pulse) begin
                    pulses++;
                    vectors++;
                    exp_e = (press_exp_q.size() != 0) ? press_exp_q.pop_front() : -1;
                    if (e != exp_e) begin
                        miscompares++;
                        $display("FAIL clean_press_edge press %0d got edge %0d want %0d", p, e, exp_e);
                    end
                end
                if (e == 6) exp_toggle = ~exp_toggle;
                vectors++;
                if (toggle_btn !== exp_toggle) begin
                    miscompares++;
                    $display("FAIL clean_press_toggle press %0d edge %0d got %b want %b", p, e, toggle_btn, exp_toggle);
                end
            end
            vectors++;
            if (pulses != 1) begin
                miscompares++;
                $display("FAIL clean_press_count press %0d got %0d want 1", p, pulses);
            end
            press_exp_q.delete();
            btn_raw = 1'b0;
            pulses = 0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (press_pulse) pulses++;
            end
            vectors++;
            if (pulses != 0 || toggle_btn !== exp_toggle) begin
                miscompares++;
                $display("FAIL release_no_toggle press %0d got pulses=%0d toggle=%b want pulses=0 toggle=%b",
                         p, pulses, toggle_btn, exp_toggle);
            end
        end
    endtask

    task automatic test_bounce();
        int pat[5] = '{1, 0, 1, 1, 0};
        int pulses;
        int exp_e;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i < 5) ? pat[i][0] : 1'b0;
            tick();
            if (press_pulse) pulses++;
        end
        vectors++;
        if (pulses != 0 || toggle_btn !== exp_toggle) begin
            miscompares++;
            $display("FAIL bounce got pulses=%0d toggle=%b want pulses=0 toggle=%b", pulses, toggle_btn, exp_toggle);
        end
        // high for DEB_CYCLES-1 cycles: one short of acceptance
        pulses = 0;
        for (int e = 1; e <= 15; e++) begin
            btn_raw = (e <= 3);
            tick();
            if (press_pulse) pulses++;
        end
        vectors++;
        if (pulses != 0 || toggle_btn !== exp_toggle) begin
            miscompares++;
            $display("FAIL bounce_short got pulses=%0d toggle=%b want pulses=0 toggle=%b", pulses, toggle_btn, exp_toggle);
        end
        // high for exactly DEB_CYCLES cycles: accepted
        pulses = 0;
        press_exp_q.push_back(6);
        for (int e = 1; e <= 16; e++) begin
            btn_raw = (e <= 4);
            tick();
            if (press_pulse) begin
                pulses++;
                vectors++;
                exp_e = (press_exp_q.size() != 0) ? press_exp_q.pop_front() : -1;
                if (e != exp_e) begin
                    miscompares++;
                    $display("FAIL bounce_exact_edge got edge %0d want %0d", e, exp_e);
                end
            end
        end
        press_exp_q.delete();
        exp_toggle = ~exp_toggle;
        vectors++;
        if (pulses != 1 || toggle_btn !== exp_toggle) begin
            miscompares++;
            $display("FAIL bounce_exact got pulses=%0d toggle=%b want pulses=1 toggle=%b", pulses, toggle_btn, exp_toggle);
        end
        btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_capture();
        data_in = 32'hDEADBEEF; data_valid = 1'b1;
        data_exp_q.push_back(32'hDEADBEEF);
        tick();
        data_valid = 1'b0;
        exp_word = data_exp_q.pop_front();
        vectors++;
        if (data_bits !== exp_word) begin
            miscompares++;
            $display("FAIL capture got %h want %h", data_bits, exp_word);
        end
        freeze = 1'b1;
        tick();
        vectors++;
        if (frozen !== 1'b0) begin
            miscompares++;
            $display("FAIL frozen_latency1 got %b want 0", frozen);
        end
        tick();
        vectors++;
        if (frozen !== 1'b1) begin
            miscompares++;
            $display("FAIL frozen_latency2 got %b want 1", frozen);
        end
        tick();
        data_in = 32'h12345678; data_valid = 1'b1;
        data_exp_q.push_back(32'hDEADBEEF);
        tick();
        data_valid = 1'b0;
        exp_word = data_exp_q.pop_front();
        vectors++;
        if (data_bits !== exp_word) begin
            miscompares++;
            $display("FAIL frozen_drop got %h want %h", data_bits, exp_word);
        end
        freeze = 1'b0;
        repeat (3) tick();
        vectors++;
        if (data_bits !== 32'hDEADBEEF || frozen !== 1'b0) begin
            miscompares++;
            $display("FAIL unfreeze_no_replay got %h frozen=%b want deadbeef frozen=0", data_bits, frozen);
        end
        data_in = 32'hCAFEF00D; data_valid = 1'b1;
        data_exp_q.push_back(32'hCAFEF00D);
        tick();
        data_valid = 1'b0;
        exp_word = data_exp_q.pop_front();
        vectors++;
        if (data_bits !== exp_word) begin
            miscompares++;
            $display("FAIL capture_after_unfreeze got %h want %h", data_bits, exp_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            data_in = w; data_valid = 1'b1;
            data_exp_q.push_back(w);
            tick();
            exp_word = data_exp_q.pop_front();
            vectors++;
            if (data_bits !== exp_word) begin
                miscompares++;
                $display("FAIL back_to_back word %0d got %h want %h", i, data_bits, exp_word);
            end
        end
        data_valid = 1'b0;
        data_in = ~exp_word;
        tick();
        vectors++;
        if (data_bits !== exp_word) begin
            miscompares++;
            $display("FAIL hold_without_valid got %h want %h", data_bits, exp_word);
        end
    endtask

    task automatic test_scan_tick();
        int pulses;
        int exp_n;
        RST_N = 1'b0; btn_raw = 1'b0;
        tick();
        RST_N = 1'b1;
        exp_toggle = 1'b1;
        for (int n = 5; n <= 20; n += 5) tick_exp_q.push_back(n);
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            if (scan_tick) begin
                pulses++;
                vectors++;
                exp_n = (tick_exp_q.size() != 0) ? tick_exp_q.pop_front() : -1;
                if (n != exp_n) begin
                    miscompares++;
                    $display("FAIL scan_tick_cycle got cycle %0d want %0d", n, exp_n);
                end
            end
            tick();
        end
        vectors++;
        if (pulses != 4 || tick_exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scan_tick_count got %0d pulses want 4", pulses);
        end
        tick_exp_q.delete();
    endtask

`ifdef AUTO_TOGGLE_EN
    task automatic test_auto_toggle();
        RST_N = 1'b0; btn_raw = 1'b0;
        tick();
        RST_N = 1'b1;
        exp_toggle = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e % 8 == 0) exp_toggle = ~exp_toggle;
            vectors++;
            if (toggle_btn !== exp_toggle || press_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL auto_toggle edge %0d got %b/%b want %b/0", e, toggle_btn, press_pulse, exp_toggle);
            end
        end
    endtask
`endif

    initial begin
        RST_N = 1'b0; btn_raw = 1'b0; freeze = 1'b0;
        data_in = '0; data_valid = 1'b0;
        test_reset();
`ifndef AUTO_TOGGLE_EN
        test_clean_press();
        test_bounce();
`endif
        test_capture();
        test_back_to_back();
        test_scan_tick();
`ifdef AUTO_TOGGLE_EN
        test_auto_toggle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/vis_input_conditioner.md
Name: vis_input_conditioner

Overview:
Front-end stage directly upstream of the 32-bit seven-segment visualizer. Conditions the raw board push-button into a clean half-select level (toggle_btn: 1 = low half "L", 0 = high half "H"). Captures the CPU result word into a stable display register (data_bits), with an optional freeze, so the scanned display never shows mid-update values. Also issues a periodic scan-tick for display pacing.

Parameters:
DEB_CYCLES, 16'd50000, consecutive stable synchronized samples needed to accept a button level change (min 2)
TICK_DIV, 16'd1000, CLK cycles per scan_tick pulse (min 2)
AUTO_PERIOD, 32'd50000000, cycles between automatic half swaps (AUTO_TOGGLE_EN only)

Ports:
CLK  in  1  system clock, all logic on posedge
RST_N  in  1  synchronous active-low reset
btn_raw  in  1  asynchronous, bouncy push-button, active-high
freeze  in  1  asynchronous level switch; 1 = hold displayed word
data_in  in  32  CPU result word
data_valid  in  1  1-cycle qualifier for data_in, synchronous to CLK
data_bits  out  32  held word to visualizer
toggle_btn  out  1  half-select level to visualizer
press_pulse  out  1  1-cycle pulse per accepted press
scan_tick  out  1  1-cycle pulse every TICK_DIV cycles
frozen  out  1  synchronized freeze status

Behaviour:
- Reset (RST_N=0 at posedge) clears: data_bits=0, toggle_btn=1, press_pulse=0, scan_tick=0, frozen=0, synchronizers=0, debounce state=RELEASED, all counters=0. Reset mid-debounce abandons the pending change.
- btn_raw and freeze each pass through a 2-flop synchronizer; only synchronized values are used.
- Debounce FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; counter deb_cnt:
  RELEASED: sync=1 -> PRESS_WAIT, deb_cnt=1.
  PRESS_WAIT: sync=0 -> RELEASED, deb_cnt=0. Sync=1 and deb_cnt==DEB_CYCLES-1 -> PRESSED, and press_pulse=1 plus toggle_btn inverted on that same edge. Otherwise deb_cnt+1.
  PRESSED: sync=0 -> RELEASE_WAIT, deb_cnt=1.
  RELEASE_WAIT: sync=1 -> PRESSED. Sync=0 and deb_cnt==DEB_CYCLES-1 -> RELEASED. Otherwise deb_cnt+1. Release never toggles.
- Latency: btn_raw held high from edge k -> toggle_btn and press_pulse change at edge k+2+DEB_CYCLES-1. A bounce shorter than DEB_CYCLES produces no toggle. Holding the button gives exactly one toggle.
- Capture: on data_valid=1 and frozen=0, data_bits<=data_in on the next edge (1-cycle latency). data_valid while frozen=1 is dropped and is not replayed on unfreeze. frozen is the synchronized freeze (2-cycle latency).
- scan_tick: free-running counter 0..TICK_DIV-1, wraps to 0. scan_tick=1 for the cycle in which the counter equals TICK_DIV-1. The first pulse occurs TICK_DIV cycles after reset release.
- All counters are saturation-free and wrap only as stated. Widths: deb_cnt and tick counter 16 bits; auto counter 32 bits.

Optional Feature:
AUTO_TOGGLE_EN: when defined, a 32-bit counter inverts toggle_btn every AUTO_PERIOD cycles while FSM==RELEASED. An accepted press restarts the counter at 0. If an auto swap and an accepted press coincide, only one inversion occurs (the press wins), and the counter resets. press_pulse is unaffected by auto swaps. When undefined, toggle_btn changes only on accepted presses and no auto counter exists.

Test Plan:
- Reset: hold RST_N=0 3 cycles with btn_raw=1, data_valid=1 -> data_bits=0, toggle_btn=1, press_pulse=0 throughout. First toggle 2+DEB_CYCLES-1 edges after release.
- Clean press, DEB_CYCLES=4: btn_raw 0->1 at edge 10, held 20 cycles -> toggle_btn 1->0 and a single press_pulse at edge 15. No change on release. A second press returns toggle_btn to 1.
- Bounce, DEB_CYCLES=4: btn_raw pattern 1,0,1,1,0 then stable 0 -> toggle_btn stays 1, press_pulse never asserted.
- Capture/freeze: data_in=32'hDEADBEEF with data_valid -> data_bits=DEADBEEF next edge. Set freeze, wait 3 cycles, data_in=32'h12345678 valid -> data_bits stays DEADBEEF. Clear freeze -> still DEADBEEF until the next valid.
- scan_tick, TICK_DIV=5: over 20 cycles after reset, exactly 4 single-cycle pulses at cycles 5, 10, 15, 20.
- AUTO_TOGGLE_EN, AUTO_PERIOD=8, no press -> toggle_btn inverts every 8 cycles. A press accepted on a swap cycle -> single inversion, and the next auto swap comes 8 cycles later.
